// File: rtl/tlc1543_scan_sched.sv
// Channel scan scheduler for the TLC1543 frame engine: walks an 11-bit channel
// mask, issues one frame per channel plus a flush frame, and realigns the one-frame result pipeline.
module tlc1543_scan_sched #(
    parameter int CONV_WAIT   = 1100,
    parameter int SCAN_GAP    = 50000,
    parameter int ACK_TIMEOUT = 4095
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [10:0] ch_mask,
    output logic        conv_req,
    output logic [3:0]  conv_addr,
    input  logic        conv_ack,
    input  logic [9:0]  conv_data,
    output logic        res_valid,
    output logic [3:0]  res_ch,
    output logic [9:0]  res_data,
    output logic        scan_done,
    output logic        timeout,
    output logic        busy
);

    localparam int WW = $clog2(CONV_WAIT + 1);
    localparam int GW = $clog2(SCAN_GAP + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(CONV_WAIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SCAN_GAP - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

    state_t        state_q, state_d;
    logic [10:0]   shadow_q, shadow_d;
    logic [3:0]    ptr_q, ptr_d;
    logic          flush_q, flush_d;
    logic [3:0]    tag_q, tag_d;
    logic          tag_valid_q, tag_valid_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          conv_req_q, conv_req_d;
    logic [3:0]    conv_addr_q, conv_addr_d;
    logic          res_valid_q, res_valid_d;
    logic [3:0]    res_ch_q, res_ch_d;
    logic [9:0]    res_data_q, res_data_d;
    logic          scan_done_q, scan_done_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          start_s;
    logic [4:0]    next_s;

    function automatic logic [3:0] lowest_ch(input logic [10:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 10; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above cur
    function automatic logic [4:0] next_ch(input logic [10:0] m, input logic [3:0] cur);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 10; i >= 0; i--) begin
            if (m[i] && (4'(i) > cur)) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign next_s = next_ch(shadow_q, ptr_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        ptr_d       = ptr_q;
        flush_d     = flush_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;
        conv_addr_d = conv_addr_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        scan_done_d = 1'b0;
        timeout_d   = 1'b0;
        busy_d      = scan_done_q ? 1'b0 : busy_q;
        start_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_en && (ch_mask != 11'd0)) begin
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (conv_ack) begin
                    if (tag_valid_q) begin
                        res_valid_d = 1'b1;
                        res_ch_d    = tag_q;
                        res_data_d  = conv_data;
                    end else begin
                        res_valid_d = 1'b0;
                    end
                    tag_d       = conv_addr_q;
                    tag_valid_d = ~flush_q;
                    if (flush_q) begin
                        scan_done_d = 1'b1;
                        gap_cnt_d   = {GW{1'b0}};
                        state_d     = GAP;
                    end else begin
                        wait_cnt_d = {WW{1'b0}};
                        state_d    = WAIT;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (wait_cnt_q == WAIT_LAST) begin
                    to_cnt_d = {TW{1'b0}};
                    state_d  = REQ;
                    if (next_s[4]) begin
                        ptr_d       = next_s[3:0];
                        conv_addr_d = next_s[3:0];
                    end else begin
                        // Flush frame re-addresses the first channel so the next priming read is sane
                        flush_d     = 1'b1;
                        conv_addr_d = lowest_ch(shadow_q);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (!scan_en) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    if (ch_mask != 11'd0) begin
                        start_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_s) begin
            shadow_d    = ch_mask;
            ptr_d       = lowest_ch(ch_mask);
            conv_addr_d = lowest_ch(ch_mask);
            flush_d     = 1'b0;
            tag_valid_d = 1'b0;
            to_cnt_d    = {TW{1'b0}};
            busy_d      = 1'b1;
            state_d     = REQ;
        end else begin
            start_s = 1'b0;
        end

        conv_req_d = (state_d == REQ);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= 11'd0;
            ptr_q       <= 4'd0;
            flush_q     <= 1'b0;
            tag_q       <= 4'd0;
            tag_valid_q <= 1'b0;
            wait_cnt_q  <= {WW{1'b0}};
            gap_cnt_q   <= {GW{1'b0}};
            to_cnt_q    <= {TW{1'b0}};
            conv_req_q  <= 1'b0;
            conv_addr_q <= 4'd0;
            res_valid_q <= 1'b0;
            res_ch_q    <= 4'd0;
            res_data_q  <= 10'd0;
            scan_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            ptr_q       <= ptr_d;
            flush_q     <= flush_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            conv_req_q  <= conv_req_d;
            conv_addr_q <= conv_addr_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            scan_done_q <= scan_done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign conv_req  = conv_req_q;
    assign conv_addr = conv_addr_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign scan_done = scan_done_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tlc1543_scan_sched.sv
// Scoreboard bench for tlc1543_scan_sched: a frame-engine model answers requests,
// monitors compare requested addresses and tagged results against queued expectations.
module tb_tlc1543_scan_sched;

    localparam int CW = 8;
    localparam int SG = 40;
    localparam int AT = 30;

    logic        clk_50m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        scan_en = 1'b0;
    logic [10:0] ch_mask = 11'd0;
    logic        conv_ack = 1'b0;
    logic [9:0]  conv_data = 10'd0;
    logic        conv_req;
    logic [3:0]  conv_addr;
    logic        res_valid;
    logic [3:0]  res_ch;
    logic [9:0]  res_data;
    logic        scan_done;
    logic        timeout;
    logic        busy;

    tlc1543_scan_sched #(.CONV_WAIT(CW), .SCAN_GAP(SG), .ACK_TIMEOUT(AT)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
        .conv_req(conv_req), .conv_addr(conv_addr), .conv_ack(conv_ack),
        .conv_data(conv_data), .res_valid(res_valid), .res_ch(res_ch),
        .res_data(res_data), .scan_done(scan_done), .timeout(timeout), .busy(busy)
    );

    always #10 clk_50m = ~clk_50m;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [14:0] exp_res[$];
    logic [3:0]  exp_addr[$];
    logic [9:0]  eng_q[$];
    bit          eng_on = 1'b0;
    int          eng_lat = 3;
    int          spur_req = 0;
    logic        req_prev = 1'b0;
    logic [14:0] e_res;
    logic [3:0]  e_addr;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_sig(input int sel, input logic lvl, input int budget, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit) begin
            @(negedge clk_50m);
            cyc++;
            if (((sel == 0) ? conv_req : scan_done) == lvl) begin
                hit = 1'b1;
            end else if (cyc >= budget) begin
                n_vec++;
                n_bad++;
                $display("FAIL wait_bound sel=%0d: no event after %0d cycles", sel, cyc);
                hit = 1'b1;
            end
        end
    endtask

    // Frame engine model: acks after eng_lat cycles of conv_req, or once on a spurious request
    initial begin : engine
        int hi;
        int spur_done;
        hi = 0;
        spur_done = 0;
        forever begin
            @(negedge clk_50m);
            if (conv_ack) begin
                conv_ack = 1'b0;
                hi = 0;
            end else if (spur_req != spur_done) begin
                spur_done = spur_req;
                conv_ack  = 1'b1;
                conv_data = 10'h3FF;
            end else if (eng_on && conv_req) begin
                hi++;
                if (hi >= eng_lat) begin
                    conv_ack  = 1'b1;
                    conv_data = (eng_q.size() > 0) ? eng_q.pop_front() : 10'd0;
                    hi = 0;
                end
            end else begin
                hi = 0;
            end
        end
    end

    // Result monitor
    always @(negedge clk_50m) begin
        if (rst_n && res_valid) begin
            if (exp_res.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL res_unexpected: got ch=%0d data=0x%0h, expected no result", res_ch, res_data);
            end else begin
                e_res = exp_res.pop_front();
                check("result{done,ch,data}", {17'd0, scan_done, res_ch, res_data}, {17'd0, e_res});
            end
        end else if (rst_n && scan_done) begin
            n_vec++;
            n_bad++;
            $display("FAIL scan_done_alone: got scan_done=1 without res_valid, expected both");
        end
    end

    // Request monitor
    always @(negedge clk_50m) begin
        if (conv_req && !req_prev) begin
            if (exp_addr.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL req_unexpected: got request to %0d, expected none", conv_addr);
            end else begin
                e_addr = exp_addr.pop_front();
                check("conv_addr", int'(conv_addr), int'(e_addr));
            end
        end
        req_prev = conv_req;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        bit quiet;
        logic [9:0] dv;

        // Reset state
        repeat (3) @(negedge clk_50m);
        check("rst_conv_req", conv_req, 0);
        check("rst_conv_addr", conv_addr, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_data", res_data, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk_50m);

        // Two channels 2 and 10
        eng_on = 1'b1;
        eng_q.push_back(10'h111); eng_q.push_back(10'h222); eng_q.push_back(10'h333);
        exp_addr.push_back(4'd2); exp_addr.push_back(4'd10); exp_addr.push_back(4'd2);
        exp_res.push_back({1'b0, 4'd2, 10'h222});
        exp_res.push_back({1'b1, 4'd10, 10'h333});
        ch_mask = 11'h404;
        scan_en = 1'b1;
        wait_sig(0, 1'b1, 50, c);
        check("t1_busy_start", busy, 1);
        wait_sig(1, 1'b1, 500, c);
        check("t1_busy_at_done", busy, 1);
        scan_en = 1'b0;
        @(negedge clk_50m);
        check("t1_busy_fall", busy, 0);
        repeat (5) @(negedge clk_50m);
        check("t1_res_left", exp_res.size(), 0);
        check("t1_addr_left", exp_addr.size(), 0);

        // All eleven channels
        for (int k = 0; k < 12; k++) begin
            dv = 10'h3C0 ^ 10'(k);
            eng_q.push_back(dv);
            exp_addr.push_back((k < 11) ? 4'(k) : 4'd0);
        end
        for (int j = 0; j < 11; j++) begin
            dv = 10'h3C0 ^ 10'(j + 1);
            exp_res.push_back({(j == 10), 4'(j), dv});
        end
        ch_mask = 11'h7FF;
        scan_en = 1'b1;
        wait_sig(0, 1'b1, 50, c);
        wait_sig(0, 1'b0, 50, c);
        wait_sig(0, 1'b1, 50, c);
        check("t2_conv_wait", c, CW);
        wait_sig(1, 1'b1, 2000, c);
        scan_en = 1'b0;
        repeat (5) @(negedge clk_50m);
        check("t2_res_left", exp_res.size(), 0);
        check("t2_addr_left", exp_addr.size(), 0);

        // Empty mask stays quiet
        ch_mask = 11'h000;
        scan_en = 1'b1;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk_50m);
            if (conv_req || busy || res_valid) quiet = 1'b0;
        end
        check("t3_mask0_quiet", quiet, 1);
        scan_en = 1'b0;

        // Ack timeout, then a spurious ack
        eng_on = 1'b0;
        exp_addr.push_back(4'd0);
        ch_mask = 11'h001;
        scan_en = 1'b1;
        wait_sig(0, 1'b1, 50, c);
        wait_sig(0, 1'b0, 200, c);
        scan_en = 1'b0;
        check("t4_req_high_cycles", c, AT);
        check("t4_timeout_pulse", timeout, 1);
        check("t4_busy_after_to", busy, 0);
        @(negedge clk_50m);
        check("t4_timeout_one_cycle", timeout, 0);
        spur_req++;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk_50m);
            if (res_valid || conv_req || busy) quiet = 1'b0;
        end
        check("t4_spurious_ack_ignored", quiet, 1);

        // Reset during the second frame's request
        eng_on = 1'b1;
        eng_q.push_back(10'h0AA);
        exp_addr.push_back(4'd2); exp_addr.push_back(4'd10);
        ch_mask = 11'h404;
        scan_en = 1'b1;
        wait_sig(0, 1'b1, 50, c);
        wait_sig(0, 1'b0, 50, c);
        wait_sig(0, 1'b1, 50, c);
        rst_n = 1'b0;
        @(negedge clk_50m);
        check("t5_rst_conv_req", conv_req, 0);
        check("t5_rst_conv_addr", conv_addr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_res_valid", res_valid, 0);
        check("t5_rst_scan_done", scan_done, 0);
        eng_q.push_back(10'h155); eng_q.push_back(10'h2AA); eng_q.push_back(10'h0F0);
        exp_addr.push_back(4'd2); exp_addr.push_back(4'd10); exp_addr.push_back(4'd2);
        exp_res.push_back({1'b0, 4'd2, 10'h2AA});
        exp_res.push_back({1'b1, 4'd10, 10'h0F0});
        rst_n = 1'b1;
        wait_sig(1, 1'b1, 500, c);
        scan_en = 1'b0;
        repeat (5) @(negedge clk_50m);
        check("t5_res_left", exp_res.size(), 0);
        check("t5_addr_left", exp_addr.size(), 0);

        // Continuous scans, gap length, mask change mid-scan
        eng_q.push_back(10'h101); eng_q.push_back(10'h102); eng_q.push_back(10'h103);
        eng_q.push_back(10'h201); eng_q.push_back(10'h202);
        exp_addr.push_back(4'd1); exp_addr.push_back(4'd2); exp_addr.push_back(4'd1);
        exp_addr.push_back(4'd3); exp_addr.push_back(4'd3);
        exp_res.push_back({1'b0, 4'd1, 10'h102});
        exp_res.push_back({1'b1, 4'd2, 10'h103});
        exp_res.push_back({1'b1, 4'd3, 10'h202});
        ch_mask = 11'h006;
        scan_en = 1'b1;
        wait_sig(0, 1'b1, 50, c);
        ch_mask = 11'h008;
        wait_sig(1, 1'b1, 500, c);
        wait_sig(0, 1'b1, 200, c);
        check("t6_scan_gap", c, SG);
        check("t6_busy_restart", busy, 1);
        wait_sig(1, 1'b1, 500, c);
        scan_en = 1'b0;
        repeat (5) @(negedge clk_50m);
        check("t6_res_left", exp_res.size(), 0);
        check("t6_addr_left", exp_addr.size(), 0);
        check("t6_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
